// File: rtl/ram_ctrl.sv
// -----------------------------------------------------------------------------
// ram_ctrl -- word-organised RAM model with a fixed-latency request/ready port,
// serving the cache's RAM interface.
//
// Parameters
//   ADDRESS_WIDTH  byte-address width (default 16); the memory holds
//                  2**(ADDRESS_WIDTH-2) 32-bit words.
//   LATENCY        ACCESS-state cycles per transfer, 1..15 (default 2).
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   ram_address      byte address, bits [1:0] ignored
//   ram_rd / ram_wr  read / write request (write wins when both are high)
//   ram_data_wr      write data
//   ram_byte_enable  per-byte write mask, bit i -> byte [8i+7:8i]
//   ram_data_rd      read data, meaningful in the ram_ready cycle
//   ram_ready        one-cycle completion pulse per word transfer
//   rd_count/wr_count  completed-transfer counters (only when the macro
//                      RAM_CTRL_STATS_EN is defined)
//
// Handshake: the requester raises ram_rd or ram_wr and holds it (with address
// and data stable) until it sees ram_ready. The request is sampled only in
// IDLE; ACCESS, DONE and GAP ignore it, so a request dropped after sampling
// still completes, and the two GAP cycles give the requester time to advance
// its registered address before the next sample. Back-to-back transfers
// complete every LATENCY+4 cycles.
//
// The FSM state is visible to checkers as the signal `state`.
// -----------------------------------------------------------------------------
module ram_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [31:0]              ram_data_wr,
    input  logic [3:0]               ram_byte_enable,
    output logic [31:0]              ram_data_rd,
    output logic                     ram_ready
`ifdef RAM_CTRL_STATS_EN
    ,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
`endif
);

    localparam int IDX_W = ADDRESS_WIDTH - 2;
    localparam int WORDS = 2 ** IDX_W;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);
    // GAP lasts two cycles: loaded with 1 on entry, leaves when it reads 0.
    localparam logic [3:0] GAP_INIT = 4'd1;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "ram_ctrl: LATENCY=%0d is outside 1..15", LATENCY);
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       lat_cnt;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_data;
    logic [3:0]       cap_be;
    logic             cap_wr;

    // Storage starts out all-zero; reset never touches it.
    logic [31:0] mem [WORDS] = '{default: 32'h0};

    // Byte-offset bits carry no meaning for a word memory.
    logic addr_lsb_unused;
    assign addr_lsb_unused = &ram_address[1:0];

    // True on the clock edge that moves ACCESS -> DONE.
    logic complete;
    assign complete = (state == ACCESS) && (lat_cnt == 4'd0);

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ram_ready   <= 1'b0;
            ram_data_rd <= 32'h0;
            lat_cnt     <= 4'd0;
            cap_idx     <= '0;
            cap_data    <= 32'h0;
            cap_be      <= 4'h0;
            cap_wr      <= 1'b0;
        end else begin
            ram_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_rd || ram_wr) begin
                        cap_idx  <= ram_address[ADDRESS_WIDTH-1:2];
                        cap_data <= ram_data_wr;
                        cap_be   <= ram_byte_enable;
                        cap_wr   <= ram_wr;
                        lat_cnt  <= LAT_INIT;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == 4'd0) begin
                        state     <= DONE;
                        ram_ready <= 1'b1;
                        if (!cap_wr) begin
                            ram_data_rd <= mem[cap_idx];
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: begin
                    lat_cnt <= GAP_INIT;
                    state   <= GAP;
                end
                GAP: begin
                    if (lat_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-masked write at completion. While rst_n is low the FSM sits in
    // IDLE, so an interrupted transfer never reaches this write.
    always_ff @(posedge clk) begin
        if (complete && cap_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (cap_be[b]) begin
                    mem[cap_idx][8*b +: 8] <= cap_data[8*b +: 8];
                end
            end
        end
    end

`ifdef RAM_CTRL_STATS_EN
    // Saturating completion counters, bumped at DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= 16'h0;
            wr_count <= 16'h0;
        end else if (complete) begin
            if (cap_wr) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_ctrl -- self-checking bench for ram_ctrl (LATENCY=2).
// A table of single transfers is applied in a loop; hand-written sequences
// cover the held-request burst, reset in the middle of ACCESS, a request
// dropped after sampling, and (with RAM_CTRL_STATS_EN) the counters.
// Expected read data is pushed to exp_q when a read is driven and popped when
// ram_ready is seen. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_ram_ctrl;

    localparam int AW  = 16;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] ram_address = '0;
    logic          ram_rd = 1'b0;
    logic          ram_wr = 1'b0;
    logic [31:0]   ram_data_wr = '0;
    logic [3:0]    ram_byte_enable = '0;
    logic [31:0]   ram_data_rd;
    logic          ram_ready;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
`endif

    ram_ctrl #(.ADDRESS_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ram_address     (ram_address),
        .ram_rd          (ram_rd),
        .ram_wr          (ram_wr),
        .ram_data_wr     (ram_data_wr),
        .ram_byte_enable (ram_byte_enable),
        .ram_data_rd     (ram_data_rd),
        .ram_ready       (ram_ready)
`ifdef RAM_CTRL_STATS_EN
        ,
        .rd_count        (rd_count),
        .wr_count        (wr_count)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model [logic [13:0]];
    logic [31:0] hold_rd = 32'h0;   // value ram_data_rd must keep between reads
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_get(input logic [15:0] a);
        if (model.exists(a[15:2])) return model[a[15:2]];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = model_get(a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        model[a[15:2]] = w;
    endtask

    // ---------------- driver ----------------
    // Starts with the DUT in IDLE, drives one request, waits for ram_ready,
    // checks latency and pulse width, then waits out the GAP so the DUT is
    // back in IDLE on return.
    task automatic xfer(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input bit drop_early,
                        input string tag);
        int  n;
        bit  got;
        logic [31:0] e;
        @(negedge clk);
        ram_rd = rd; ram_wr = wr; ram_address = addr;
        ram_data_wr = wdata; ram_byte_enable = be;
        if (!wr) exp_q.push_back(exp_rd);
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (drop_early && n == 1) begin
                ram_rd = 1'b0; ram_wr = 1'b0;
            end
            if (ram_ready) got = 1'b1;
        end
        check({tag, " latency"}, 32'(n), 32'(LAT + 1));
        if (got) begin
            if (wr) begin
                check({tag, " rd data held on write"}, ram_data_rd, hold_rd);
                model_write(addr, wdata, be);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, " rd data"}, ram_data_rd, e);
                hold_rd = e;
            end
        end else if (!wr && exp_q.size() > 0) begin
            void'(exp_q.pop_back());
        end
        ram_rd = 1'b0; ram_wr = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready pulse width"}, 32'(ram_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          k, n;
        int unsigned t[4];
        bit          saw;
        logic [15:0] a;
        logic [31:0] d, e;
        logic [3:0]  be;

        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 16'h0014, 32'hAABBCCDD, 4'hF, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0014, 32'h11223344, 4'h5, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0014, 32'h0,        4'h0, 32'hAA22CC44};
        vecs[5]  = '{1'b1, 1'b1, 16'h0020, 32'h5A5A5A5A, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0020, 32'h0,        4'h0, 32'h5A5A5A5A};
        vecs[7]  = '{1'b0, 1'b1, 16'h0014, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0014, 32'h0,        4'h0, 32'hAA22CC44};
        vecs[9]  = '{1'b1, 1'b0, 16'h0017, 32'h0,        4'h0, 32'hAA22CC44};
        vecs[10] = '{1'b1, 1'b0, 16'h0100, 32'h0,        4'h0, 32'h00000000};

        // Reset values, then release just after an edge so the very next
        // edge is the first one that may sample a request.
        #12;
        check("reset ram_ready", 32'(ram_ready), 32'd0);
        check("reset ram_data_rd", ram_data_rd, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Table-driven single transfers.
        for (int i = 0; i < NVEC; i++) begin
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].be, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Request dropped right after sampling still completes.
        xfer(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, "dropped rd");

        // Line fill: ram_rd held high, address advanced at each ready.
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b1, 16'(16'h0040 + 4*i), 32'hC0DE0000 + 32'(i * 32'h1111),
                 4'hF, 32'h0, 1'b0, $sformatf("fill wr%0d", i));
        end
        @(negedge clk);
        ram_address = 16'h0040; ram_rd = 1'b1; ram_wr = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE0000 + 32'(i * 32'h1111));
        k = 0; n = 0;
        while (k < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (ram_ready) begin
                t[k] = cyc;
                e = exp_q.pop_front();
                check($sformatf("burst data%0d", k), ram_data_rd, e);
                hold_rd = e;
                k++;
                ram_address = 16'(16'h0040 + 4*k);
                if (k == 4) ram_rd = 1'b0;
            end
        end
        ram_rd = 1'b0;
        check("burst pulse count", 32'(k), 32'd4);
        for (int i = 1; i < k; i++) begin
            check($sformatf("burst spacing%0d", i), t[i] - t[i-1], 32'(LAT + 4));
        end
        repeat (3) @(posedge clk);

        // Reset in the middle of ACCESS of a write.
        xfer(1'b0, 1'b1, 16'h0030, 32'h01020304, 4'hF, 32'h0, 1'b0, "pre-reset wr");
        @(negedge clk);
        ram_address = 16'h0030; ram_wr = 1'b1; ram_data_wr = 32'hCAFEF00D; ram_byte_enable = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; ram_wr = 1'b0;
        #1;
        check("mid-access reset ram_data_rd", ram_data_rd, 32'h0);
        hold_rd = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ram_ready) saw = 1'b1;
        end
        check("no ready after abandoned write / while idle", 32'(saw), 32'd0);
        xfer(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0, 32'h01020304, 1'b0, "post-reset rd");

        // Random traffic against the byte-lane model.
        for (int r = 0; r < 10; r++) begin
            a  = 16'(16'h0200 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                xfer(1'b0, 1'b1, a, d, be, 32'h0, 1'b0, $sformatf("rand wr%0d", r));
            end else begin
                xfer(1'b1, 1'b0, a, 32'h0, 4'h0, model_get(a), 1'b0, $sformatf("rand rd%0d", r));
            end
        end

`ifdef RAM_CTRL_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stats reset rd_count", 32'(rd_count), 32'd0);
        check("stats reset wr_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_rd = 32'h0;
        xfer(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "stats rd0");
        xfer(1'b0, 1'b1, 16'h0300, 32'h12345678, 4'hF, 32'h0, 1'b0, "stats wr0");
        xfer(1'b1, 1'b0, 16'h0300, 32'h0, 4'h0, 32'h12345678, 1'b0, "stats rd1");
        xfer(1'b0, 1'b1, 16'h0304, 32'h87654321, 4'h3, 32'h0, 1'b0, "stats wr1");
        xfer(1'b1, 1'b0, 16'h0304, 32'h0, 4'h0, 32'h00004321, 1'b0, "stats rd2");
        check("stats rd_count", 32'(rd_count), 32'd3);
        check("stats wr_count", 32'(wr_count), 32'd2);
`endif

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
